seg_display_scan: RTL and testbench

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

---
 rtl/seg_display_scan_pkg.sv | 37 +++
 rtl/seg_display_scan_hex.sv | 37 +++
 rtl/seg_display_scan.sv | 123 ++++++++++++
 tb/tb_seg_display_scan.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scan_pkg
// Description : Shared constants, the pending/display record type and the
//               leading-zero helper for the 4-digit scanned display.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_display_scan_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] SEL_OFF    = 4'b1111;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
  } disp_rec_t;

  // True when digit idx lies above the highest nonzero digit; digit0 never blanks.
  function automatic logic lz_blank(input logic [15:0] v, input idx_t idx);
    logic blank;
    blank = 1'b0;
    case (idx)
      2'd3:    blank = (v[15:12] == 4'h0);
      2'd2:    blank = (v[15:8]  == 8'h00);
      2'd1:    blank = (v[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_scan_hex.sv
`default_nettype none
// ============================================================================
// Module      : hex7segment_5
// Description : Combinational hex nibble to active-low 7-segment glyph,
//               bit order {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
module hex7segment_5 (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scan
// Description : Multiplexed 4-digit hex display driver with frame-atomic
//               updates, anti-ghosting dead time and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scan
  import seg_display_scan_pkg::*;
#(
  parameter int DIV_BITS     = 16,
  parameter int BLANK_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wr,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  sel,
  output logic        frame_start
);

  localparam logic [DIV_BITS-1:0] c_blank_cycles = BLANK_CYCLES[DIV_BITS-1:0];
  localparam idx_t                c_last_idx     = idx_t'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0] r_cnt;
  idx_t                r_idx;
  disp_rec_t           r_pending;
  disp_rec_t           r_display;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [3:0]          r_sel;
  logic                r_frame_start;

  logic                w_tick;
  logic                w_commit;
  logic [3:0]          w_nibble;
  logic [6:0]          w_hex_seg;
  logic [6:0]          w_seg_next;
  logic                w_dp_next;
  logic [3:0]          w_sel_next;

  assign w_tick   = en & (&r_cnt);
  assign w_commit = w_tick & (r_idx == c_last_idx);
  assign w_nibble = r_display.value[{r_idx, 2'b00} +: 4];

  hex7segment_5 u_hex (
    .hex (w_nibble),
    .seg (w_hex_seg)
  );

  // Disabling parks the scan at digit0, so re-enabling starts with a full blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!en) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else if (wr) begin
      r_pending <= '{value: value, dp: dp_in, lz: lz_en};
    end
  end

  // A write landing on the commit edge is picked up by the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_commit;
      if (w_commit) begin
        r_display <= r_pending;
      end
    end
  end

  always_comb begin
    w_seg_next = w_hex_seg;
    if (r_display.lz && lz_blank(r_display.value, r_idx)) begin
      w_seg_next = SEG_BLANK;
    end
    w_dp_next  = ~r_display.dp[r_idx];
    w_sel_next = SEL_OFF;
    if (en && (r_cnt >= c_blank_cycles)) begin
      w_sel_next[r_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_sel <= SEL_OFF;
    end else begin
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
      r_sel <= w_sel_next;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign sel         = r_sel;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_scan
// Description : Self-checking bench for seg_display_scan (DIV_BITS=4, BLANK_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scan;

  localparam int DIV_BITS     = 4;
  localparam int BLANK_CYCLES = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        wr    = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  sel;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dpi;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } vec_t;

  vec_t vecs [6];

  seg_display_scan #(
    .DIV_BITS     (DIV_BITS),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .wr          (wr),
    .value       (value),
    .dp_in       (dp_in),
    .lz_en       (lz_en),
    .seg         (seg),
    .dp          (dp),
    .sel         (sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] v, input logic [3:0] d, input logic l);
    value = v;
    dp_in = d;
    lz_en = l;
    wr    = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  // Counts negedges until frame_start is seen; start is the edges already elapsed.
  task automatic count_to_fs(input int start, input int exp_n, input string name);
    int n;
    bit seen;
    n    = start;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (frame_start) seen = 1'b1;
    end
    chk(name, 16'(n), 16'(exp_n));
  endtask

  task automatic wait_fs(input string name);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (frame_start) seen = 1'b1;
    end
    chk(name, 16'(seen), 16'd1);
  endtask

  // Entered on the frame_start negedge; samples each slot mid-way.
  task automatic check_frame(input string tag, input logic [3:0][6:0] es, input logic [3:0] ed);
    logic [3:0] se;
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 8 : 16) @(negedge clk);
      se    = 4'b1111;
      se[k] = 1'b0;
      chk($sformatf("%s seg d%0d", tag, k), 16'(seg), 16'(es[k]));
      chk($sformatf("%s dp d%0d", tag, k), 16'(dp), 16'(ed[k]));
      chk($sformatf("%s sel d%0d", tag, k), 16'(sel), 16'(se));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit fs_seen;

    vecs[0] = '{value: 16'h1A3F, dpi: 4'b0100, lz: 1'b0, seg: {S1, SA, S3, SF}, dpn: 4'b1011};
    vecs[1] = '{value: 16'h00B0, dpi: 4'b0000, lz: 1'b1, seg: {BL, BL, SB, S0}, dpn: 4'b1111};
    vecs[2] = '{value: 16'h0000, dpi: 4'b1001, lz: 1'b1, seg: {BL, BL, BL, S0}, dpn: 4'b0110};
    vecs[3] = '{value: 16'h8421, dpi: 4'b0000, lz: 1'b1, seg: {S8, S4, S2, S1}, dpn: 4'b1111};
    vecs[4] = '{value: 16'hC0E0, dpi: 4'b0010, lz: 1'b1, seg: {SC, S0, SE, S0}, dpn: 4'b1101};
    vecs[5] = '{value: 16'h0500, dpi: 4'b0000, lz: 1'b0, seg: {S0, S5, S0, S0}, dpn: 4'b1111};

    // Reset state and start-up timing
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset seg", 16'(seg), 16'(BL));
    chk("reset dp", 16'(dp), 16'd1);
    chk("reset sel", 16'(sel), 16'hF);
    chk("reset frame_start", 16'(frame_start), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("startup blank1 sel", 16'(sel), 16'hF);
    @(negedge clk);
    chk("startup blank2 sel", 16'(sel), 16'hF);
    @(negedge clk);
    chk("startup digit0 sel", 16'(sel), 16'hE);
    chk("startup digit0 seg", 16'(seg), 16'(S0));
    count_to_fs(3, 64, "first frame_start latency");

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].value, vecs[i].dpi, vecs[i].lz);
      wait_fs($sformatf("vec%0d frame_start", i));
      check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dpn);
    end

    // Write on the frame_start cycle: old value holds for this frame
    wait_fs("pre wr@fs frame_start");
    do_write(16'h0001, 4'h0, 1'b0);
    repeat (7) @(negedge clk);
    chk("wr@fs old frame d0", 16'(seg), 16'(S0));
    wait_fs("wr@fs next frame_start");
    repeat (8) @(negedge clk);
    chk("wr@fs new frame d0", 16'(seg), 16'(S1));

    // Write on the commit (tick) cycle: commit takes the earlier pending value
    do_write(16'h0002, 4'h0, 1'b0);
    repeat (54) @(negedge clk);
    do_write(16'h0003, 4'h0, 1'b0);
    chk("commit-cycle frame_start", 16'(frame_start), 16'd1);
    repeat (8) @(negedge clk);
    chk("wr@commit uses old pending d0", 16'(seg), 16'(S2));
    wait_fs("wr@commit next frame_start");
    repeat (8) @(negedge clk);
    chk("wr@commit later frame d0", 16'(seg), 16'(S3));

    // Enable drop mid slot 2, write while disabled, then resume
    repeat (32) @(negedge clk);
    chk("slot2 sel before en drop", 16'(sel), 16'hB);
    en = 1'b0;
    @(negedge clk);
    chk("en drop sel", 16'(sel), 16'hF);
    do_write(16'h0009, 4'hF, 1'b0);
    fs_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (frame_start || (sel != 4'hF)) fs_seen = 1'b1;
    end
    chk("disabled: no frame_start, sel off", 16'(fs_seen), 16'd0);
    en = 1'b1;
    @(negedge clk);
    chk("resume blank1 sel", 16'(sel), 16'hF);
    @(negedge clk);
    chk("resume blank2 sel", 16'(sel), 16'hF);
    @(negedge clk);
    chk("resume digit0 sel", 16'(sel), 16'hE);
    chk("resume digit0 seg", 16'(seg), 16'(S3));
    count_to_fs(3, 64, "resume frame_start latency");
    repeat (8) @(negedge clk);
    chk("write while disabled d0 seg", 16'(seg), 16'(S9));
    chk("write while disabled d0 dp", 16'(dp), 16'd0);

    // Asynchronous reset mid-frame; pending write is lost
    repeat (16) @(negedge clk);
    chk("pre-reset slot1 sel", 16'(sel), 16'hD);
    do_write(16'h1234, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset seg", 16'(seg), 16'(BL));
    chk("async reset dp", 16'(dp), 16'd1);
    chk("async reset sel", 16'(sel), 16'hF);
    chk("async reset frame_start", 16'(frame_start), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_fs(0, 64, "post-reset frame_start latency");
    check_frame("post-reset", {S0, S0, S0, S0}, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
